sweep_stim_ctrl: RTL and testbench
==================================

Name: sweep_stim_ctrl

Overview:
- Sequencer that drives an exhaustive input sweep into a combinational or sequential benchmark DUT: every vector 0 to 2^N_IN-1, in ascending order.
- For each vector it waits a settle window, captures the DUT response, and streams the vector/response pair out over a ready/valid log port.
- It compacts all responses into a MISR signature and compares it against a golden signature, giving a pass/fail flag for trojan screening.
- It sits between the stimulus-logging harness and the DUT instance.

Parameters:
- N_IN, 4, DUT input width; sweep length is 2^N_IN vectors.
- N_OUT, 1, DUT output width.
- SETTLE, 1, cycles to wait after applying a vector before capture; legal range 1..255.
- SIG_W, 16, MISR width; must be at least N_OUT.
- POLY, 16'h1021, MISR feedback polynomial, SIG_W bits.

Ports:
- CK  in  1  clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  pulse; begins a sweep; accepted only in IDLE or DONE.
- abort  in  1  returns to IDLE from any state next cycle; results are not updated.
- vec_out  out  N_IN  vector driven to the DUT inputs.
- vec_valid  out  1  high while vec_out is being applied (APPLY/SETTLE/CAPTURE/LOG).
- dut_out  in  N_OUT  DUT response.
- log_valid  out  1  log pair valid.
- log_ready  in  1  log consumer ready.
- log_vec  out  N_IN  vector of the pair being logged.
- log_resp  out  N_OUT  captured response of the pair being logged.
- busy  out  1  high in any state other than IDLE/DONE.
- done  out  1  level, high in DONE.
- signature  out  SIG_W  MISR value.
- golden_sig  in  SIG_W  expected signature; sampled on entry to DONE.
- mismatch  out  1  signature != golden_sig, valid while done=1.

Behaviour:
- Reset: state IDLE; vec_out, log_vec, log_resp, signature = 0; vec_valid, log_valid, busy, done, mismatch = 0.
- FSM states: IDLE, APPLY, SETTLE, CAPTURE, LOG, DONE.
- IDLE/DONE + start: vec_out=0, signature=0, settle counter cleared, mismatch=0, done=0; go to APPLY.
- APPLY (1 cycle): load settle counter with SETTLE; go to SETTLE.
- SETTLE: decrement each cycle; after SETTLE cycles go to CAPTURE.
- CAPTURE (1 cycle): register dut_out into log_resp; log_vec=vec_out.
  - Update MISR: fb=signature[SIG_W-1]; signature <= (signature<<1) ^ (fb ? POLY : 0) ^ zero-extended dut_out.
  - Go to LOG.
- LOG: log_valid=1; log_vec/log_resp stable until log_ready=1 (transfer on the valid&ready edge).
  - After transfer: if vec_out is all-ones, go to DONE; else vec_out+1 and go to APPLY.
  - log_valid drops the cycle after the transfer.
- vec_out is held constant from APPLY through LOG; it changes only on the LOG->APPLY edge.
- Per-vector latency with log_ready tied high: SETTLE+3 cycles.
- Full sweep: done rises 2^N_IN*(SETTLE+3)+1 edges after the start edge (65 for defaults).
- DONE: done=1; mismatch <= (signature != golden_sig) registered on entry; outputs hold until start/abort/reset.
- Boundary cases:
  - start while busy: ignored.
  - start and abort in the same cycle: abort wins.
  - abort in LOG: log_valid drops next cycle with no transfer.
  - vec_out all-ones: no wrap to 0; the sweep terminates.
  - log_ready high outside LOG: no effect.
  - reset mid-sweep: full reset values next edge.

Optional Feature:
- Macro: SWEEP_RARE_CNT_EN.
- Enabled:
  - Adds output rare_cnt, width N_IN+1: number of vectors whose captured dut_out != 0.
  - Adds input rare_thresh, width N_IN+1.
  - Adds output rare_flag = (rare_cnt != 0) && (rare_cnt <= rare_thresh), registered on DONE entry.
  - rare_cnt clears on start, increments in CAPTURE, saturates at 2^N_IN.
  - Both new outputs are 0 at reset.
- Disabled: ports and logic are absent; all other behaviour is identical.

Test Plan:
- DUT=AND4, log_ready=1, golden_sig=16'h0001, start pulse:
  - 16 log transfers in order 0000..1111, log_resp=1 only for 1111.
  - signature=16'h0001, mismatch=0, done at edge 65.
- Same sweep with golden_sig=16'h0000 -> mismatch=1, signature=16'h0001.
- log_ready low for 5 cycles during vector 0101:
  - log_valid, log_vec=0101 and vec_out held stable.
  - Exactly 16 transfers; final signature unchanged.
- abort asserted during SETTLE of vector 0011 -> IDLE next cycle, busy=0, done=0.
  - A new start gives a full 16-vector sweep beginning at 0000.
- reset asserted mid-LOG -> all outputs at reset values next edge; start pulse during the active sweep is ignored (no restart at 0000).
- SWEEP_RARE_CNT_EN, AND4 DUT, rare_thresh=2 -> rare_cnt=1, rare_flag=1.
  - OR4 DUT -> rare_cnt=15, rare_flag=0.

Source files
------------

// File: rtl/sweep_stim_ctrl.sv
// Exhaustive input-sweep sequencer with a MISR-based response signature for trojan screening.
// Optional rare-response counter is enabled by defining SWEEP_RARE_CNT_EN.
module sweep_stim_ctrl #(
    parameter int                N_IN   = 4,
    parameter int                N_OUT  = 1,
    parameter int                SETTLE = 1,
    parameter int                SIG_W  = 16,
    parameter logic [SIG_W-1:0]  POLY   = 16'h1021
) (
    input  logic              CK,
    input  logic              reset,
    input  logic              start,
    input  logic              abort,
    output logic [N_IN-1:0]   vec_out,
    output logic              vec_valid,
    input  logic [N_OUT-1:0]  dut_out,
    output logic              log_valid,
    input  logic              log_ready,
    output logic [N_IN-1:0]   log_vec,
    output logic [N_OUT-1:0]  log_resp,
    output logic              busy,
    output logic              done,
    output logic [SIG_W-1:0]  signature,
    input  logic [SIG_W-1:0]  golden_sig,
`ifdef SWEEP_RARE_CNT_EN
    output logic [N_IN:0]     rare_cnt,
    input  logic [N_IN:0]     rare_thresh,
    output logic              rare_flag,
`endif
    output logic              mismatch
);

    typedef enum logic [2:0] {
        IDLE,
        APPLY,
        SETTLE_ST,
        CAPTURE,
        LOG,
        DONE
    } state_t;

    state_t             state_q, state_d;
    logic [N_IN-1:0]    vec_q, vec_d;
    logic [7:0]         cnt_q, cnt_d;
    logic [N_IN-1:0]    log_vec_q, log_vec_d;
    logic [N_OUT-1:0]   log_resp_q, log_resp_d;
    logic [SIG_W-1:0]   sig_q, sig_d;
    logic               mismatch_q, mismatch_d;
`ifdef SWEEP_RARE_CNT_EN
    localparam logic [N_IN:0] RARE_MAX = {1'b1, {N_IN{1'b0}}};
    logic [N_IN:0]      rare_cnt_q, rare_cnt_d;
    logic               rare_flag_q, rare_flag_d;
`endif

    always_comb begin
        state_d    = state_q;
        vec_d      = vec_q;
        cnt_d      = cnt_q;
        log_vec_d  = log_vec_q;
        log_resp_d = log_resp_q;
        sig_d      = sig_q;
        mismatch_d = mismatch_q;
`ifdef SWEEP_RARE_CNT_EN
        rare_cnt_d  = rare_cnt_q;
        rare_flag_d = rare_flag_q;
`endif
        // Abort leaves every result register untouched; only the state returns home.
        if (abort) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        vec_d      = '0;
                        sig_d      = '0;
                        cnt_d      = '0;
                        mismatch_d = 1'b0;
`ifdef SWEEP_RARE_CNT_EN
                        rare_cnt_d  = '0;
                        rare_flag_d = 1'b0;
`endif
                        state_d    = APPLY;
                    end
                end
                APPLY: begin
                    cnt_d   = 8'(SETTLE);
                    state_d = SETTLE_ST;
                end
                SETTLE_ST: begin
                    cnt_d = cnt_q - 8'd1;
                    if (cnt_q <= 8'd1) begin
                        state_d = CAPTURE;
                    end
                end
                CAPTURE: begin
                    log_resp_d = dut_out;
                    log_vec_d  = vec_q;
                    sig_d      = {sig_q[SIG_W-2:0], 1'b0}
                               ^ (sig_q[SIG_W-1] ? POLY : '0)
                               ^ SIG_W'(dut_out);
`ifdef SWEEP_RARE_CNT_EN
                    if ((dut_out != '0) && (rare_cnt_q != RARE_MAX)) begin
                        rare_cnt_d = rare_cnt_q + (N_IN+1)'(1);
                    end
`endif
                    state_d    = LOG;
                end
                LOG: begin
                    if (log_ready) begin
                        // The all-ones vector ends the sweep instead of wrapping to zero.
                        if (&vec_q) begin
                            mismatch_d = (sig_q != golden_sig);
`ifdef SWEEP_RARE_CNT_EN
                            rare_flag_d = (rare_cnt_q != '0) && (rare_cnt_q <= rare_thresh);
`endif
                            state_d    = DONE;
                        end else begin
                            vec_d   = vec_q + N_IN'(1);
                            state_d = APPLY;
                        end
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge CK) begin
        if (reset) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            cnt_q      <= '0;
            log_vec_q  <= '0;
            log_resp_q <= '0;
            sig_q      <= '0;
            mismatch_q <= 1'b0;
`ifdef SWEEP_RARE_CNT_EN
            rare_cnt_q  <= '0;
            rare_flag_q <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            cnt_q      <= cnt_d;
            log_vec_q  <= log_vec_d;
            log_resp_q <= log_resp_d;
            sig_q      <= sig_d;
            mismatch_q <= mismatch_d;
`ifdef SWEEP_RARE_CNT_EN
            rare_cnt_q  <= rare_cnt_d;
            rare_flag_q <= rare_flag_d;
`endif
        end
    end

    assign vec_out   = vec_q;
    assign vec_valid = (state_q == APPLY) || (state_q == SETTLE_ST) ||
                       (state_q == CAPTURE) || (state_q == LOG);
    assign log_valid = (state_q == LOG);
    assign log_vec   = log_vec_q;
    assign log_resp  = log_resp_q;
    assign busy      = (state_q != IDLE) && (state_q != DONE);
    assign done      = (state_q == DONE);
    assign signature = sig_q;
    assign mismatch  = mismatch_q;
`ifdef SWEEP_RARE_CNT_EN
    assign rare_cnt  = rare_cnt_q;
    assign rare_flag = rare_flag_q;
`endif

endmodule

// File: tb/tb_sweep_stim_ctrl.sv
// Scoreboard bench for sweep_stim_ctrl: expected log pairs are queued at sweep start and
// popped by an independent monitor on every valid&ready transfer.
module tb_sweep_stim_ctrl;

    logic        CK = 1'b0;
    logic        reset, start, abort, log_ready;
    logic [3:0]  vec_out, log_vec;
    logic        vec_valid, log_valid, busy, done, mismatch;
    logic [0:0]  dut_out, log_resp;
    logic [15:0] signature, golden_sig;
`ifdef SWEEP_RARE_CNT_EN
    logic [4:0]  rare_cnt, rare_thresh;
    logic        rare_flag;
`endif

    // Benchmark circuit under sweep: mode 0 is AND4, mode 1 is OR4.
    int dut_mode = 0;
    always_comb dut_out = (dut_mode == 0) ? 1'(&vec_out) : 1'(|vec_out);

    always #5 CK = ~CK;

    sweep_stim_ctrl dut (
        .CK         (CK),
        .reset      (reset),
        .start      (start),
        .abort      (abort),
        .vec_out    (vec_out),
        .vec_valid  (vec_valid),
        .dut_out    (dut_out),
        .log_valid  (log_valid),
        .log_ready  (log_ready),
        .log_vec    (log_vec),
        .log_resp   (log_resp),
        .busy       (busy),
        .done       (done),
        .signature  (signature),
        .golden_sig (golden_sig),
`ifdef SWEEP_RARE_CNT_EN
        .rare_cnt   (rare_cnt),
        .rare_thresh(rare_thresh),
        .rare_flag  (rare_flag),
`endif
        .mismatch   (mismatch)
    );

    typedef struct packed {
        logic [3:0] v;
        logic       r;
    } pair_t;

    pair_t exp_q[$];
    int    checks    = 0;
    int    errors    = 0;
    int    transfers = 0;
    int    edges;
    bit    seen;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a transfer happens on the next rising edge whenever valid&ready is seen here.
    always @(negedge CK) begin
        pair_t e;
        if (!reset && log_valid && log_ready) begin
            transfers++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL unexpected_transfer: got vec %0h expected none", log_vec);
            end else begin
                e = exp_q.pop_front();
                checkOutput("log_vec", 32'(log_vec), 32'(e.v));
                checkOutput("log_resp", 32'(log_resp), 32'(e.r));
            end
        end
    end

    // Queue the expected sweep for the chosen circuit, then pulse start for one edge.
    task automatic applyStimulus(input int mode);
        pair_t p;
        dut_mode = mode;
        exp_q.delete();
        transfers = 0;
        for (int v = 0; v < 16; v++) begin
            p.v = 4'(v);
            p.r = (mode == 0) ? (v == 15) : (v != 0);
            exp_q.push_back(p);
        end
        @(posedge CK);
        #1 start = 1'b1;
        @(posedge CK);
        #1 start = 1'b0;
    endtask

    // Counts edges with the start edge as edge 1.
    task automatic waitDone(output int n);
        n = 1;
        while (!done && n < 300) begin
            @(posedge CK);
            #1;
            n++;
        end
        if (!done) checkOutput("done_timeout", 32'(done), 32'd1);
    endtask

    task automatic waitVec(input logic [3:0] v);
        seen = 1'b0;
        for (int i = 0; i < 200 && !seen; i++) begin
            @(posedge CK);
            #1;
            if (vec_valid && vec_out == v) seen = 1'b1;
        end
        if (!seen) checkOutput("vec_timeout", 32'(vec_out), 32'(v));
    endtask

    task automatic waitLogValid();
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(posedge CK);
            #1;
            if (log_valid) seen = 1'b1;
        end
        if (!seen) checkOutput("log_valid_timeout", 32'(log_valid), 32'd1);
    endtask

    task automatic checkDone(input logic [15:0] sig, input logic mm);
        checkOutput("done", 32'(done), 32'd1);
        checkOutput("busy_done", 32'(busy), 32'd0);
        checkOutput("signature", 32'(signature), 32'(sig));
        checkOutput("mismatch", 32'(mismatch), 32'(mm));
        checkOutput("transfers", 32'(transfers), 32'd16);
        checkOutput("queue_empty", 32'(exp_q.size()), 32'd0);
    endtask

    task automatic checkReset();
        checkOutput("rst_vec_out", 32'(vec_out), 32'd0);
        checkOutput("rst_vec_valid", 32'(vec_valid), 32'd0);
        checkOutput("rst_log_valid", 32'(log_valid), 32'd0);
        checkOutput("rst_log_vec", 32'(log_vec), 32'd0);
        checkOutput("rst_log_resp", 32'(log_resp), 32'd0);
        checkOutput("rst_busy", 32'(busy), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_signature", 32'(signature), 32'd0);
        checkOutput("rst_mismatch", 32'(mismatch), 32'd0);
`ifdef SWEEP_RARE_CNT_EN
        checkOutput("rst_rare_cnt", 32'(rare_cnt), 32'd0);
        checkOutput("rst_rare_flag", 32'(rare_flag), 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        start      = 1'b0;
        abort      = 1'b0;
        log_ready  = 1'b1;
        golden_sig = 16'h0001;
`ifdef SWEEP_RARE_CNT_EN
        rare_thresh = 5'd2;
`endif
        repeat (3) @(posedge CK);
        #1;
        checkReset();
        reset = 1'b0;

        $display("[TB] AND4 sweep, golden 0001");
        applyStimulus(0);
        checkOutput("busy_running", 32'(busy), 32'd1);
        waitDone(edges);
        checkOutput("done_edge", 32'(edges), 32'd65);
        checkDone(16'h0001, 1'b0);
`ifdef SWEEP_RARE_CNT_EN
        checkOutput("rare_cnt_and", 32'(rare_cnt), 32'd1);
        checkOutput("rare_flag_and", 32'(rare_flag), 32'd1);
`endif

        $display("[TB] AND4 sweep, golden 0000");
        golden_sig = 16'h0000;
        applyStimulus(0);
        waitDone(edges);
        checkDone(16'h0001, 1'b1);

        // OR4 accumulates fifteen ones; with 16 vectors the MSB never reaches feedback.
        $display("[TB] OR4 sweep, golden 7FFF");
        golden_sig = 16'h7FFF;
        applyStimulus(1);
        waitDone(edges);
        checkOutput("done_edge_or", 32'(edges), 32'd65);
        checkDone(16'h7FFF, 1'b0);
`ifdef SWEEP_RARE_CNT_EN
        checkOutput("rare_cnt_or", 32'(rare_cnt), 32'd15);
        checkOutput("rare_flag_or", 32'(rare_flag), 32'd0);
`endif

        $display("[TB] log_ready stall on vector 0101");
        golden_sig = 16'h0001;
        applyStimulus(0);
        waitVec(4'b0101);
        log_ready = 1'b0;
        waitLogValid();
        for (int i = 0; i < 5; i++) begin
            checkOutput("stall_log_valid", 32'(log_valid), 32'd1);
            checkOutput("stall_log_vec", 32'(log_vec), 32'h5);
            checkOutput("stall_vec_out", 32'(vec_out), 32'h5);
            @(posedge CK);
            #1;
        end
        log_ready = 1'b1;
        waitDone(edges);
        checkDone(16'h0001, 1'b0);

        $display("[TB] abort during settle of vector 0011");
        applyStimulus(0);
        waitVec(4'b0011);
        @(posedge CK);
        #1 abort = 1'b1;
        @(posedge CK);
        #1 abort = 1'b0;
        checkOutput("abort_busy", 32'(busy), 32'd0);
        checkOutput("abort_done", 32'(done), 32'd0);
        checkOutput("abort_vec_valid", 32'(vec_valid), 32'd0);
        checkOutput("abort_transfers", 32'(transfers), 32'd3);
        start = 1'b1;
        abort = 1'b1;
        @(posedge CK);
        #1;
        start = 1'b0;
        abort = 1'b0;
        checkOutput("start_abort_busy", 32'(busy), 32'd0);
        applyStimulus(0);
        waitDone(edges);
        checkOutput("restart_done_edge", 32'(edges), 32'd65);
        checkDone(16'h0001, 1'b0);

        $display("[TB] start while busy, then reset in LOG");
        applyStimulus(1);
        waitVec(4'b0101);
        start = 1'b1;
        @(posedge CK);
        #1 start = 1'b0;
        waitVec(4'b1001);
        log_ready = 1'b0;
        waitLogValid();
        checkOutput("pre_reset_log_vec", 32'(log_vec), 32'h9);
        reset = 1'b1;
        @(posedge CK);
        #1;
        checkReset();
        checkOutput("reset_transfers", 32'(transfers), 32'd9);
        reset     = 1'b0;
        log_ready = 1'b1;
        exp_q.delete();
        repeat (3) @(posedge CK);
        #1;
        checkOutput("idle_after_reset", 32'(busy), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
